// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues single-word reads to a 1R/1W memory,
// and presents each fetched word with its PC to decode over a valid/ready handshake.
module instr_fetch #(
  parameter int          MEM_DEPTH  = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0,
  localparam int         ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req_valid,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_data_valid,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (fetch_en) state_nxt = S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: if (mem_data_valid) state_nxt = S_HOLD;
      S_HOLD: if (instr_ready) state_nxt = fetch_en ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // A redirect abandons whatever is in flight and restarts from the new PC.
    if (redirect_valid) state_nxt = fetch_en ? S_REQ : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      instr        <= '0;
      instr_pc     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end else if (state == S_WAIT && mem_data_valid) begin
        instr    <= mem_rdata;
        instr_pc <= pc;
        pc       <= pc + 32'd4;
      end
    end
  end

  // Word address truncates the PC, so fetches wrap through memory every MEM_DEPTH words.
  assign mem_addr      = pc[ADDR_WIDTH+1:2];
  assign mem_req_valid = (state == S_REQ);
  assign mem_we        = 1'b0;
  assign instr_valid   = (state == S_HOLD);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder with variable latency, a transaction-level
// reference model of the fetch stream, directed scenarios and a randomized soak.
module tb_instr_fetch;

  localparam int MEM_DEPTH = 8;
  localparam int AW        = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic [AW-1:0] mem_addr;
  logic          mem_req_valid;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic          mem_data_valid;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          misalign_err;

  instr_fetch #(.MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .mem_addr(mem_addr), .mem_req_valid(mem_req_valid), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  logic [31:0] image [MEM_DEPTH] = '{32'h00a38313, 32'h01400393, 32'h00730e33, 32'h40638eb3,
                                     32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Memory responder state: a new request always replaces any older one still pending.
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_word = '0;
  logic        prev_req;
  logic [AW-1:0] prev_addr;

  // Reference model: what is in flight, what is being presented, and the PC stream.
  bit          m_req = 0, m_wait = 0, m_hold = 0, m_mis = 0;
  logic [31:0] m_pc = '0, m_instr = '0, m_ipc = '0;

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return image[int'((byte_addr / 4) % MEM_DEPTH)];
  endfunction

  task automatic predict();
    if (reset) begin
      m_req = 0; m_wait = 0; m_hold = 0; m_mis = 0;
      m_pc = 32'h0; m_instr = '0; m_ipc = '0;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) m_mis = 1;
      m_req = fetch_en; m_wait = 0; m_hold = 0;
    end else if (m_req) begin
      m_req = 0; m_wait = 1;
    end else if (m_wait) begin
      if (mem_data_valid) begin
        m_instr = word_at(m_pc); m_ipc = m_pc; m_pc = m_pc + 32'd4;
        m_wait = 0; m_hold = 1;
      end
    end else if (m_hold) begin
      if (instr_ready) begin m_hold = 0; m_req = fetch_en; end
    end else begin
      m_req = fetch_en;
    end
  endtask

  task automatic mem_step();
    if (prev_req === 1'b1) begin
      mem_word = image[prev_addr];
      mem_cnt  = mem_lat;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
    end
    mem_data_valid = (mem_cnt == 1);
    mem_rdata      = mem_data_valid ? mem_word : $urandom;
  endtask

  task automatic compare_all();
    chk("req", {31'b0, mem_req_valid}, {31'b0, m_req});
    if (m_req) chk("addr", {29'b0, mem_addr}, (m_pc / 4) % MEM_DEPTH);
    chk("valid", {31'b0, instr_valid}, {31'b0, m_hold});
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("misalign", {31'b0, misalign_err}, {31'b0, m_mis});
    chk("we", {31'b0, mem_we}, 32'h0);
  endtask

  task automatic tick();
    predict();
    prev_req  = mem_req_valid;
    prev_addr = mem_addr;
    @(posedge clk);
    #1;
    mem_step();
    compare_all();
  endtask

  task automatic wait_req(input string tag, input int max);
    int n = 0;
    while (mem_req_valid !== 1'b1 && n < max) begin tick(); n++; end
    chk(tag, {31'b0, mem_req_valid}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_seq [4] = '{32'h00a38313, 32'h01400393, 32'h00730e33, 32'h40638eb3};
    int nvalid;
    reset = 1; fetch_en = 1; instr_ready = 1; redirect_valid = 0; redirect_pc = '0;
    mem_data_valid = 0; mem_rdata = '0;

    // Reset state, then sequential fetch with decode always ready.
    tick();
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'b0, mem_req_valid}, 32'h0);
    reset = 0;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (instr_valid && nvalid < 4) begin
        chk("seq_instr", instr, exp_seq[nvalid]);
        chk("seq_pc", instr_pc, 32'(4 * nvalid));
        nvalid++;
      end else if (instr_valid) begin
        nvalid++;
      end
    end
    chk("seq_count", nvalid, 32'd4);

    // Backpressure while holding the second instruction.
    reset = 1; tick(); reset = 0;
    repeat (6) tick();
    instr_ready = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", {31'b0, instr_valid}, 32'h1);
      chk("bp_instr", instr, 32'h01400393);
      chk("bp_pc", instr_pc, 32'h4);
      chk("bp_noreq", {31'b0, mem_req_valid}, 32'h0);
    end
    instr_ready = 1;
    tick();
    chk("bp_req", {31'b0, mem_req_valid}, 32'h1);
    chk("bp_addr", {29'b0, mem_addr}, 32'h2);

    // Redirect while waiting on the word at pc=4.
    reset = 1; tick(); reset = 0;
    repeat (5) tick();
    redirect_valid = 1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 0;
    chk("rw_req", {31'b0, mem_req_valid}, 32'h1);
    chk("rw_addr", {29'b0, mem_addr}, 32'h4);
    chk("rw_valid", {31'b0, instr_valid}, 32'h0);
    repeat (2) tick();
    chk("rw_ipc", instr_pc, 32'h10);
    chk("rw_instr", instr, 32'h00000013);

    // Redirect in HOLD together with ready.
    redirect_valid = 1; redirect_pc = 32'h8;
    tick();
    redirect_valid = 0;
    chk("rh_valid", {31'b0, instr_valid}, 32'h0);
    repeat (2) tick();
    chk("rh_ipc", instr_pc, 32'h8);
    chk("rh_instr", instr, 32'h00730e33);

    // Wrap through the end of memory.
    redirect_valid = 1; redirect_pc = 32'h1C;
    tick();
    redirect_valid = 0;
    repeat (2) tick();
    chk("wr_ipc_1c", instr_pc, 32'h1C);
    tick();
    chk("wr_addr0", {29'b0, mem_addr}, 32'h0);
    repeat (2) tick();
    chk("wr_ipc_20", instr_pc, 32'h20);
    chk("wr_instr", instr, 32'h00a38313);

    // Misaligned redirect: sticky error.
    redirect_valid = 1; redirect_pc = 32'h6;
    tick();
    redirect_valid = 0;
    chk("ma_err", {31'b0, misalign_err}, 32'h1);
    chk("ma_addr", {29'b0, mem_addr}, 32'h1);
    repeat (10) tick();
    chk("ma_sticky", {31'b0, misalign_err}, 32'h1);

    // Reset in WAIT, then fetch_en gating.
    wait_req("mw_req", 10);
    tick();
    reset = 1; fetch_en = 0;
    tick();
    reset = 0;
    chk("mw_valid", {31'b0, instr_valid}, 32'h0);
    chk("mw_err", {31'b0, misalign_err}, 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("gate_noreq", {31'b0, mem_req_valid}, 32'h0);
    end
    fetch_en = 1;
    tick();
    chk("gate_req", {31'b0, mem_req_valid}, 32'h1);
    chk("gate_addr", {29'b0, mem_addr}, 32'h0);

    // Randomized soak with variable memory latency and stray data-valid pulses.
    for (int k = 0; k < 2000; k++) begin
      reset          = ($urandom_range(0, 99) == 0);
      fetch_en       = ($urandom_range(0, 99) < 85);
      instr_ready    = ($urandom_range(0, 99) < 65);
      redirect_valid = ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: redirect_pc = 32'($urandom_range(0, 63));
      endcase
      mem_lat = $urandom_range(1, 3);
      if (!m_wait && $urandom_range(0, 7) == 0) begin
        mem_data_valid = 1'b1;
        mem_rdata      = $urandom;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
